xor_frame_checksum: RTL and testbench

//  Streaming, parametrised successor to the 2-input xor_gate.
//  - Folds a framed stream of WIDTH-bit words into a column-wise XOR checksum.
//  - Also produces overall bit parity and frame length.
//  - Valid/ready handshake on both sides.
//  - Sits between a word source (UART/RAM reader) and a consumer that checks or appends the checksum.

---
 rtl/xor_frame_checksum_if.sv | 23 ++
 rtl/xor_frame_checksum.sv | 72 +++++++
 tb/tb_xor_frame_checksum.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/xor_frame_checksum_if.sv
// xor_frame_checksum_if: word stream in, per-frame checksum result out.
// Optional exp_xor/out_match members exist only with XOR_CHECK_EN.
interface xor_frame_checksum_if #(parameter int WIDTH = 8, parameter int MAX_LEN = 16);
    localparam int LW = $clog2(MAX_LEN + 1);
    logic             in_valid, in_ready, in_last;
    logic [WIDTH-1:0] in_data;
    logic             out_valid, out_ready, out_parity, out_err;
    logic [WIDTH-1:0] out_xor;
    logic [LW-1:0]    out_len;
`ifdef XOR_CHECK_EN
    logic [WIDTH-1:0] exp_xor;
    logic             out_match;
    modport master (output in_valid, in_data, in_last, out_ready, exp_xor,
                    input  in_ready, out_valid, out_xor, out_parity, out_len, out_err, out_match);
    modport slave  (input  in_valid, in_data, in_last, out_ready, exp_xor,
                    output in_ready, out_valid, out_xor, out_parity, out_len, out_err, out_match);
`else
    modport master (output in_valid, in_data, in_last, out_ready,
                    input  in_ready, out_valid, out_xor, out_parity, out_len, out_err);
    modport slave  (input  in_valid, in_data, in_last, out_ready,
                    output in_ready, out_valid, out_xor, out_parity, out_len, out_err);
`endif
endinterface

// File: rtl/xor_frame_checksum.sv
// xor_frame_checksum: folds framed words into XOR checksum, parity, saturating length and overlength flag.
// XOR_CHECK_EN adds exp_xor compare producing out_match.
module xor_frame_checksum #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
) (
    input logic                 clk,
    input logic                 rst,
    xor_frame_checksum_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [0:0] ACC  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] acc, acc_n, xr;
    logic [LW-1:0]    cnt, cnt_n, len;
    logic             err, err_n, oerr, sat, beat;

    assign bus.in_ready   = ~rst & (state == ACC);
    assign bus.out_valid  = (state == HOLD);
    assign bus.out_xor    = xr;
    assign bus.out_parity = ^xr;
    assign bus.out_len    = len;
    assign bus.out_err    = oerr;

    assign beat  = bus.in_valid & bus.in_ready;
    assign sat   = (cnt == LW'(MAX_LEN));
    assign acc_n = acc ^ bus.in_data;
    assign cnt_n = sat ? cnt : cnt + LW'(1);
    assign err_n = err | sat;

`ifdef XOR_CHECK_EN
    logic match;
    assign bus.out_match = match;
    always_ff @(posedge clk)
        if (rst)
            match <= 1'b0;
        else if (beat && bus.in_last)
            match <= (acc_n == bus.exp_xor);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            xr    <= '0;
            len   <= '0;
            oerr  <= 1'b0;
        end else if (state == ACC) begin
            if (beat) begin
                acc <= acc_n;
                cnt <= cnt_n;
                err <= err_n;
                if (bus.in_last) begin
                    state <= HOLD;
                    xr    <= acc_n;
                    len   <= cnt_n;
                    oerr  <= err_n;
                end
            end
        end else if (bus.out_ready) begin
            // result stays on the outputs; only the accumulator restarts
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_xor_frame_checksum.sv
// tb_xor_frame_checksum: random frames checked against a frame-level model plus directed literal cases.
// Covers the XOR_CHECK_EN ports when that macro is defined.
module tb_xor_frame_checksum;
    localparam int MAXL = 16;

    typedef struct {
        logic [7:0] x;
        int         len;
        bit         err;
        bit         m;
    } res_t;

    logic clk = 0;
    logic rst = 0;
    int checks = 0;
    int errors = 0;
    int rmode  = 1;
    res_t mq[$];
    logic [7:0] fr[$];
    logic [7:0] ex = 0;

    xor_frame_checksum_if #(.WIDTH(8), .MAX_LEN(MAXL)) bus ();
    xor_frame_checksum #(.WIDTH(8), .MAX_LEN(MAXL)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) if (rmode == 0) #1 bus.out_ready = 1'($urandom % 2);

    always @(negedge clk)
        if (!rst && bus.out_valid) begin
            if (mq.size() == 0) chk("unexpected_out_valid", 1, 0);
            else begin
                chk("model_xor", 32'(bus.out_xor), 32'(mq[0].x));
                chk("model_parity", 32'(bus.out_parity), 32'($countones(mq[0].x) % 2));
                chk("model_len", 32'(bus.out_len), 32'(mq[0].len));
                chk("model_err", 32'(bus.out_err), 32'(mq[0].err));
                chk("in_ready_in_hold", 32'(bus.in_ready), 0);
`ifdef XOR_CHECK_EN
                chk("model_match", 32'(bus.out_match), 32'(mq[0].m));
`endif
                if (bus.out_ready) void'(mq.pop_front());
            end
        end

    task automatic send_frame(input bit gaps, input bit term);
        logic [7:0] x = 0;
        int n = fr.size();
        bit a;
        int t;
        for (int i = 0; i < n; i++) begin
            while (gaps && $urandom % 3 == 0) begin
                bus.in_valid = 0;
                bus.in_last  = 1'($urandom % 2);
                bus.in_data  = 8'($urandom);
                @(posedge clk); #1;
            end
            bus.in_valid = 1;
            bus.in_data  = fr[i];
            bus.in_last  = term && (i == n - 1);
`ifdef XOR_CHECK_EN
            bus.exp_xor  = ex;
`endif
            t = 0;
            do begin
                @(negedge clk);
                a = bus.in_ready;
                @(posedge clk); #1;
                t++;
            end while (!a && t < 100);
            if (!a) chk("accept_timeout", 0, 1);
            x ^= fr[i];
        end
        bus.in_valid = 0;
        bus.in_last  = 0;
        if (term) mq.push_back('{x, (n > MAXL) ? MAXL : n, n > MAXL, x == ex});
    endtask

    task automatic wait_result(input string name, input logic [7:0] x, input int len, input bit err);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.out_valid && t < 200);
        chk({name, "_valid"}, 32'(bus.out_valid), 1);
        chk({name, "_xor"}, 32'(bus.out_xor), 32'(x));
        chk({name, "_len"}, 32'(bus.out_len), 32'(len));
        chk({name, "_err"}, 32'(bus.out_err), 32'(err));
    endtask

    task automatic do_reset();
        rst = 1;
        bus.in_valid = 0;
        bus.in_last  = 0;
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        rst = 0;
    endtask

    initial begin
        bus.in_valid = 0; bus.in_last = 0; bus.in_data = 0; bus.out_ready = 0;
`ifdef XOR_CHECK_EN
        bus.exp_xor = 0;
`endif
        // reset
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_xor", 32'(bus.out_xor), 0);
        chk("rst_out_len", 32'(bus.out_len), 0);
        chk("rst_out_err", 32'(bus.out_err), 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk); #1;

        // basic three-word frame, latency one cycle
        bus.out_ready = 1;
        fr = '{8'h0F, 8'h33, 8'h55};
        send_frame(0, 1);
        @(negedge clk);
        chk("f3_latency", 32'(bus.out_valid), 1);
        chk("f3_xor", 32'(bus.out_xor), 32'h69);
        chk("f3_parity", 32'(bus.out_parity), 0);
        chk("f3_len", 32'(bus.out_len), 3);
        chk("f3_err", 32'(bus.out_err), 0);
        @(posedge clk); #1;

        // single word held under backpressure
        bus.out_ready = 0;
        fr = '{8'h01};
        send_frame(0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.out_valid), 1);
            chk("hold_xor", 32'(bus.out_xor), 1);
            chk("hold_parity", 32'(bus.out_parity), 1);
            chk("hold_in_ready", 32'(bus.in_ready), 0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        chk("release_in_ready", 32'(bus.in_ready), 1);
        chk("release_out_valid", 32'(bus.out_valid), 0);
        @(posedge clk); #1;

        // overlength then exact-length frame
        fr.delete();
        repeat (17) fr.push_back(8'hFF);
        send_frame(0, 1);
        wait_result("over", 8'hFF, 16, 1);
        @(posedge clk); #1;
        fr.delete();
        repeat (16) fr.push_back(8'hFF);
        send_frame(1, 1);
        wait_result("exact", 8'h00, 16, 0);
        @(posedge clk); #1;

        // reset mid-frame
        fr = '{8'h11, 8'h22};
        send_frame(0, 0);
        do_reset();
        fr = '{8'hAA};
        send_frame(0, 1);
        wait_result("after_rst", 8'hAA, 1, 0);
        @(posedge clk); #1;

`ifdef XOR_CHECK_EN
        fr = '{8'h12, 8'h34};
        ex = 8'h26;
        send_frame(0, 1);
        wait_result("match_ok", 8'h26, 2, 0);
        chk("match_ok_flag", 32'(bus.out_match), 1);
        @(posedge clk); #1;
        ex = 8'h27;
        send_frame(0, 1);
        wait_result("match_bad", 8'h26, 2, 0);
        chk("match_bad_flag", 32'(bus.out_match), 0);
        @(posedge clk); #1;
`endif

        // randomized frames with random backpressure and input gaps
        rmode = 0;
        for (int f = 0; f < 30; f++) begin
            logic [7:0] x = 0;
            fr.delete();
            repeat ($urandom_range(1, 20)) fr.push_back(8'($urandom));
            foreach (fr[i]) x ^= fr[i];
            ex = ($urandom % 2) ? x : 8'($urandom);
            send_frame(1, 1);
        end
        rmode = 1;
        @(posedge clk); #1;
        bus.out_ready = 1;
        begin
            int t = 0;
            while (mq.size() != 0 && t < 200) begin
                @(posedge clk);
                t++;
            end
            chk("drain_queue_empty", 32'(mq.size()), 0);
        end
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
